// File: rtl/acc_feeder_if.sv
// Bundle of the host/stream side and accumulator-core side signals of acc_feeder.
// slave is the feeder's view; master is the view of whoever drives it.
interface acc_feeder_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int CNT_WIDTH     = 8
);
    logic                     start_i;
    logic [CNT_WIDTH-1:0]     count_i;
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;
    logic                     run_o;
    logic                     valid_o;
    logic [IN_DATA_WIDTH-1:0] number_o;
    logic                     acc_valid_i;
    logic [DWIDTH-1:0]        acc_result_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic [DWIDTH-1:0]        result_o;

    modport slave (
        input  start_i, count_i, s_valid_i, s_data_i, acc_valid_i, acc_result_i,
        output s_ready_o, run_o, valid_o, number_o, busy_o, done_o, err_o, result_o
    );

    modport master (
        output start_i, count_i, s_valid_i, s_data_i, acc_valid_i, acc_result_i,
        input  s_ready_o, run_o, valid_o, number_o, busy_o, done_o, err_o, result_o
    );
endinterface

// File: rtl/acc_feeder.sv
// Frame driver for the accumulator core: FIFO-buffers upstream numbers, issues a
// counted frame with fixed gaps, then waits (with timeout) for the core's result.
module acc_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int TIMEOUT       = 64
) (
    input  logic         clk,
    input  logic         reset,
    acc_feeder_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_RES} state_t;

    state_t state, state_nxt;

    logic [IN_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [OCC_W-1:0]         occ, occ_nxt;
    logic                     push, pop, fifo_empty;
    logic [IN_DATA_WIDTH-1:0] head;

    logic [CNT_WIDTH-1:0]     remaining, remaining_nxt;
    logic [GAP_W-1:0]         gcnt, gcnt_nxt;
    logic [TMO_W-1:0]         tcnt, tcnt_nxt;
    logic                     last_issue;

    logic                     run_nxt, valid_nxt, done_nxt, err_nxt;
    logic [IN_DATA_WIDTH-1:0] number_nxt;
    logic [DWIDTH-1:0]        result_nxt;

    assign push       = bus.s_valid_i && bus.s_ready_o;
    assign fifo_empty = (occ == '0);
    assign pop        = (state == SEND) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign last_issue = (remaining == CNT_WIDTH'(1));
    assign occ_nxt    = occ + OCC_W'(push) - OCC_W'(pop);

    // Input FIFO: occupancy is registered, so a fresh word is visible to the
    // popper only on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            bus.s_ready_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ           <= occ_nxt;
            bus.s_ready_o <= (occ_nxt != OCC_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.s_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_i && (bus.count_i != '0)) state_nxt = SEND;
            end
            SEND: begin
                if (!fifo_empty) begin
                    if (last_issue)           state_nxt = WAIT_RES;
                    else if (GAP_CYCLES == 0) state_nxt = SEND;
                    else                      state_nxt = GAP;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) state_nxt = SEND;
            end
            WAIT_RES: begin
                if (bus.acc_valid_i || (tcnt == TMO_LIM)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and frame counter; a result
    // arriving on the timeout cycle takes priority over the timeout.
    always_comb begin
        run_nxt       = bus.run_o;
        valid_nxt     = 1'b0;
        number_nxt    = '0;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        result_nxt    = bus.result_o;
        remaining_nxt = remaining;
        gcnt_nxt      = gcnt;
        tcnt_nxt      = tcnt;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.count_i != '0) begin
                        remaining_nxt = bus.count_i;
                        run_nxt       = 1'b1;
                    end else begin
                        done_nxt   = 1'b1;
                        result_nxt = '0;
                    end
                end
            end
            SEND: begin
                if (!fifo_empty) begin
                    valid_nxt     = 1'b1;
                    number_nxt    = head;
                    remaining_nxt = remaining - CNT_WIDTH'(1);
                    gcnt_nxt      = '0;
                    tcnt_nxt      = '0;
                end
            end
            GAP: begin
                gcnt_nxt = gcnt + GAP_W'(1);
            end
            WAIT_RES: begin
                if (bus.acc_valid_i) begin
                    result_nxt = bus.acc_result_i;
                    done_nxt   = 1'b1;
                    run_nxt    = 1'b0;
                end else if (tcnt == TMO_LIM) begin
                    done_nxt = 1'b1;
                    err_nxt  = 1'b1;
                    run_nxt  = 1'b0;
                end else begin
                    tcnt_nxt = tcnt + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.run_o    <= 1'b0;
            bus.valid_o  <= 1'b0;
            bus.number_o <= '0;
            bus.busy_o   <= 1'b0;
            bus.done_o   <= 1'b0;
            bus.err_o    <= 1'b0;
            bus.result_o <= '0;
            remaining    <= '0;
            gcnt         <= '0;
            tcnt         <= '0;
        end else begin
            bus.run_o    <= run_nxt;
            bus.valid_o  <= valid_nxt;
            bus.number_o <= number_nxt;
            bus.busy_o   <= (state_nxt != IDLE);
            bus.done_o   <= done_nxt;
            bus.err_o    <= err_nxt;
            bus.result_o <= result_nxt;
            remaining    <= remaining_nxt;
            gcnt         <= gcnt_nxt;
            tcnt         <= tcnt_nxt;
        end
    end

    a_number_idle_zero: assert property (@(posedge clk) disable iff (reset)
        !bus.valid_o |-> (bus.number_o == '0));

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder: basic frame, ignored inputs, zero count,
// starvation, full FIFO, timeout, result/timeout tie and mid-frame reset.
module tb_acc_feeder;
    localparam int W  = 8;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    acc_feeder_if #(.IN_DATA_WIDTH(W), .DWIDTH(DW), .CNT_WIDTH(CW)) bus ();

    acc_feeder #(
        .IN_DATA_WIDTH(W), .DWIDTH(DW), .FIFO_DEPTH(4),
        .GAP_CYCLES(2), .CNT_WIDTH(CW), .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int iss_num [8];
    int iss_cyc [8];
    int n_iss;
    int run_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        tick();
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
    endtask

    task automatic start(input logic [CW-1:0] n);
        bus.start_i = 1'b1;
        bus.count_i = n;
        tick();
        bus.start_i = 1'b0;
        bus.count_i = '0;
    endtask

    task automatic core_reply(input logic [DW-1:0] r);
        bus.acc_valid_i  = 1'b1;
        bus.acc_result_i = r;
        tick();
        bus.acc_valid_i  = 1'b0;
        bus.acc_result_i = '0;
    endtask

    task automatic collect(input int n, input int budget);
        n_iss    = 0;
        run_drop = 0;
        for (int i = 0; i < budget && n_iss < n; i++) begin
            tick();
            if (!bus.run_o) run_drop++;
            if (bus.valid_o) begin
                iss_num[n_iss] = int'(bus.number_o);
                iss_cyc[n_iss] = cyc;
                n_iss++;
            end
        end
        chk("issue_count", n_iss, n);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done_o) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) chk("done_wait", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, p, i0, d, cnt, acc;
        logic [W-1:0] vals [3];
        bus.start_i      = 1'b0;
        bus.count_i      = '0;
        bus.s_valid_i    = 1'b0;
        bus.s_data_i     = '0;
        bus.acc_valid_i  = 1'b0;
        bus.acc_result_i = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_s_ready", bus.s_ready_o, 1);
        chk("rst_run",     bus.run_o,     0);
        chk("rst_valid",   bus.valid_o,   0);
        chk("rst_number",  bus.number_o,  0);
        chk("rst_busy",    bus.busy_o,    0);
        chk("rst_done",    bus.done_o,    0);
        chk("rst_err",     bus.err_o,     0);
        chk("rst_result",  bus.result_o,  0);
        reset = 1'b0;
        tick();

        // Basic frame: 1 and 3, result 4 two cycles after the last issue
        push(8'd1);
        push(8'd3);
        start(8'd2);
        e0 = cyc;
        chk("basic_run_rise", bus.run_o, 1);
        chk("basic_busy", bus.busy_o, 1);
        collect(2, 20);
        chk("basic_num0", iss_num[0], 1);
        chk("basic_num1", iss_num[1], 3);
        chk("basic_first_lat", iss_cyc[0] - e0, 1);
        chk("basic_spacing", iss_cyc[1] - iss_cyc[0], 3);
        chk("basic_run_held", run_drop, 0);
        tick();
        chk("basic_valid_pulse", bus.valid_o, 0);
        chk("basic_number_zero", bus.number_o, 0);
        chk("basic_no_early_done", bus.done_o, 0);
        core_reply(32'd4);
        chk("basic_done", bus.done_o, 1);
        chk("basic_err", bus.err_o, 0);
        chk("basic_result", bus.result_o, 4);
        chk("basic_run_fall", bus.run_o, 0);
        tick();
        chk("basic_done_pulse", bus.done_o, 0);
        chk("basic_busy_idle", bus.busy_o, 0);

        // Core result outside WAIT_RES is ignored
        core_reply(32'd99);
        chk("ign_acc_done", bus.done_o, 0);
        chk("ign_acc_result", bus.result_o, 4);

        // Zero count
        start(8'd0);
        chk("zero_done", bus.done_o, 1);
        chk("zero_err", bus.err_o, 0);
        chk("zero_result", bus.result_o, 0);
        chk("zero_run", bus.run_o, 0);
        chk("zero_busy", bus.busy_o, 0);
        tick();
        chk("zero_valid", bus.valid_o, 0);
        chk("zero_run_after", bus.run_o, 0);

        // Starvation, with a second start while busy that must be ignored
        start(8'd3);
        start(8'd1);
        vals[0] = 8'd5; vals[1] = 8'd6; vals[2] = 8'd7;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (10) begin
                tick();
                if (bus.valid_o) cnt++;
            end
            push(vals[k]);
            p = cyc;
            collect(1, 6);
            chk("starve_num", iss_num[0], int'(vals[k]));
            chk("starve_lat", iss_cyc[0] - p, 1);
        end
        chk("starve_spurious", cnt, 0);
        chk("starve_still_busy", bus.busy_o, 1);
        core_reply(32'd18);
        chk("starve_done", bus.done_o, 1);
        chk("starve_result", bus.result_o, 18);

        // Full FIFO: six offered, four accepted
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'(10 + k);
            if (bus.s_ready_o) acc++;
            tick();
            if (k == 3) chk("full_ready_low", bus.s_ready_o, 0);
        end
        bus.s_valid_i = 1'b0;
        chk("full_accepted", acc, 4);
        start(8'd4);
        collect(4, 40);
        for (int k = 0; k < 4; k++) chk("full_order", iss_num[k], 10 + k);
        chk("full_ready_back", bus.s_ready_o, 1);
        core_reply(32'd42);
        chk("full_result", bus.result_o, 42);

        // Timeout: no core response
        push(8'd9);
        start(8'd1);
        collect(1, 6);
        i0 = iss_cyc[0];
        wait_done(100, d);
        chk("tmo_latency", d - i0, 65);
        chk("tmo_err", bus.err_o, 1);
        chk("tmo_result_kept", bus.result_o, 42);
        chk("tmo_run", bus.run_o, 0);

        // Result on the timeout cycle wins
        push(8'd21);
        start(8'd1);
        collect(1, 6);
        cnt = 0;
        repeat (64) begin
            tick();
            if (bus.done_o) cnt++;
        end
        chk("tie_no_early_done", cnt, 0);
        core_reply(32'd77);
        chk("tie_done", bus.done_o, 1);
        chk("tie_err", bus.err_o, 0);
        chk("tie_result", bus.result_o, 77);

        // Reset mid-frame during GAP
        push(8'd1); push(8'd2); push(8'd3); push(8'd4);
        start(8'd3);
        collect(1, 6);
        chk("mrst_first", iss_num[0], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_run", bus.run_o, 0);
        chk("mrst_valid", bus.valid_o, 0);
        chk("mrst_busy", bus.busy_o, 0);
        chk("mrst_result", bus.result_o, 0);
        chk("mrst_s_ready", bus.s_ready_o, 1);
        chk("mrst_done", bus.done_o, 0);
        cnt = 0;
        repeat (4) begin
            tick();
            if (bus.done_o) cnt++;
        end
        start(8'd1);
        repeat (5) begin
            tick();
            if (bus.valid_o || bus.done_o) cnt++;
        end
        chk("mrst_fifo_empty", cnt, 0);
        push(8'd8);
        collect(1, 6);
        chk("mrst_new_num", iss_num[0], 8);
        core_reply(32'd8);
        chk("mrst_new_done", bus.done_o, 1);
        chk("mrst_new_result", bus.result_o, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acc_feeder.md
# acc_feeder

Frame-level driver for the accumulator core: buffers upstream numbers in a small FIFO, then issues a programmed count of them to the core as single-cycle valid pulses with a fixed inter-issue gap. It holds the core's run input high for the whole frame. After the last issue it waits for the core's result, returns it with a one-cycle done pulse, and flags a timeout if the result never arrives. It sits between the host/stream side and the accumulator core, on the core's input side.

## Interface
- IN_DATA_WIDTH, 8: width of one number.
- DWIDTH, IN_DATA_WIDTH*4: accumulator result width.
- FIFO_DEPTH, 4: input buffer entries; must be a power of 2, at least 2.
- GAP_CYCLES, 2: idle cycles inserted between consecutive issues; 0 allowed.
- CNT_WIDTH, 8: width of the frame count.
- TIMEOUT, 64: cycles to wait for a result after the last issue.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle frame start request.
- count_i  in  CNT_WIDTH  numbers in the frame; sampled with start_i.
- s_valid_i  in  1  upstream data valid.
- s_data_i  in  IN_DATA_WIDTH  upstream number.
- s_ready_o  out  1  FIFO not full.
- run_o  out  1  drives the core's run_i.
- valid_o  out  1  drives the core's valid_i; one-cycle pulse per number.
- number_o  out  IN_DATA_WIDTH  drives the core's number_i.
- acc_valid_i  in  1  core's valid_o.
- acc_result_i  in  DWIDTH  core's result_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle frame completion pulse.
- err_o  out  1  qualifies done_o; high means timeout.
- result_o  out  DWIDTH  captured result; held until the next done_o.

## Operation
- **FIFO**
  - Push when s_valid_i && s_ready_o, in any state including IDLE.
  - s_ready_o = !full, registered from the occupancy count.
  - No bypass: a word pushed in cycle N can pop in cycle N+1 at the earliest.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, SEND, GAP, WAIT_RES.
- **IDLE**
  - start_i with count_i != 0: latch remaining = count_i, set run_o = 1, go to SEND.
  - start_i with count_i == 0: done_o = 1, err_o = 0, result_o = 0; stay IDLE; run_o never asserts.
- **SEND**
  - FIFO non-empty: pop the head, assert valid_o for one cycle with number_o = head, decrement remaining.
    - remaining reaches 0: go to WAIT_RES and clear the timeout counter.
    - Otherwise: go to GAP, or stay in SEND if GAP_CYCLES == 0.
  - FIFO empty: wait with valid_o = 0. There is no timeout on starvation.
- **GAP:** count GAP_CYCLES cycles, then go to SEND.
- **WAIT_RES**
  - acc_valid_i = 1: result_o = acc_result_i, done_o = 1, err_o = 0, run_o = 0, go to IDLE.
  - Timeout counter reaches TIMEOUT with no acc_valid_i: done_o = 1, err_o = 1, result_o unchanged, run_o = 0, go to IDLE.
- **Ignored inputs**
  - acc_valid_i outside WAIT_RES.
  - start_i while busy_o = 1.
- **number_o:** 0 whenever valid_o = 0.
- **Widths:** the result passes through unmodified; remaining and the timeout counter do not wrap (the FSM leaves the state first).

## Timing
- **Reset values:** s_ready_o = 1; all other outputs 0. FIFO empty, FSM in IDLE.
- Reset mid-frame aborts at the next edge: run_o drops, FIFO contents are discarded, and no done_o is produced.
- All outputs are registered.
- run_o rises the cycle after the start_i edge.
- First valid_o is 1 cycle after run_o rises if the FIFO already holds data.
- Issue-to-issue spacing is GAP_CYCLES+1 cycles when the FIFO is non-empty.
- done_o and the result_o update appear the cycle after acc_valid_i is sampled in WAIT_RES.
- run_o falls in the same cycle that done_o rises.
- Timeout: done_o appears TIMEOUT+1 cycles after the last valid_o.
- acc_valid_i and the timeout limit in the same cycle: the result wins (err_o = 0).

## Test plan
- **Basic frame:** preload 1 and 3, start_i with count_i = 2, model core returns 4 two cycles after the last issue -> valid_o pulses with number_o 1 then 3, three cycles apart; done_o = 1, err_o = 0, result_o = 4; run_o high across the whole frame.
- **Starvation:** start with the FIFO empty and count_i = 3, push 5 / 6 / 7 ten cycles apart -> each issue follows its push by at least 1 cycle; no spurious valid_o; core returns 18 -> result_o = 18.
- **Full FIFO:** push 6 words back-to-back with the FSM idle -> s_ready_o low after 4 accepted; words 5 and 6 are dropped by upstream hold; start_i with count_i = 4 issues exactly the 4 stored words in order.
- **Timeout:** count_i = 1, core never responds -> done_o = 1 with err_o = 1 exactly 65 cycles after the issue; result_o keeps its prior value; run_o = 0.
- **Zero count:** start_i with count_i = 0 -> done_o pulse, result_o = 0, run_o and valid_o never assert.
- **Reset mid-frame:** assert reset in GAP after 1 of 3 issues -> all outputs at reset values the next cycle, s_ready_o = 1, FIFO empty, no done_o; a new frame runs normally afterward.
